// File: rtl/pattern_scan_ctrl.sv
// Serial pattern scanner: counts matches of a configurable PAT_W-bit pattern and stops after a limit.
// Optional build macro OVERLAP_EN: keep the shift history after a match so overlapping hits count.
module pattern_scan_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             start,
  input  logic             abort,
  input  logic             x,
  input  logic             x_valid,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);
  localparam logic [PAT_W-1:0]  PAT_RST  = (PAT_W == 4) ? PAT_W'(4'b0110) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   limit_q, limit_d;

  logic [PAT_W-1:0]   hist_next;
  logic [FILL_W-1:0]  fill_inc;
  logic [CNT_W-1:0]   cnt_inc;
  logic               limit_hit;

  assign hist_next = {hist_q[PAT_W-2:0], x};
  assign fill_inc  = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  // Compare one bit wider so a saturated counter can never alias onto a small limit.
  assign limit_hit = (limit_q != '0) &&
                     (({1'b0, cnt_q} + (CNT_W+1)'(1)) == {1'b0, limit_q});

  assign z = (state_q == SCAN) && x_valid && !abort &&
             (fill_q >= FILL_ARM) && (hist_next == pat_q);

  assign busy      = (state_q == SCAN);
  assign done      = (state_q == DONE);
  assign state     = state_q;
  assign match_cnt = cnt_q;

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so no path infers a latch.
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    limit_d = limit_q;

    case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (cfg_we) begin
            pat_d   = cfg_pat;
            limit_d = cfg_limit;
          end
          if (start) begin
            state_d = SCAN;
            hist_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
          end
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (x_valid) begin
          hist_d = hist_next;
          fill_d = fill_inc;
          if (z) begin
            cnt_d = cnt_inc;
`ifdef OVERLAP_EN
            fill_d = fill_inc;
`else
            fill_d = '0;
`endif
            if (limit_hit) state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: configuration registers are reset too, so the scanner has a defined pattern out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      pat_q   <= PAT_RST;
      limit_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      limit_q <= limit_d;
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl: a driver pushes model predictions, a monitor pops and compares.
module tb_pattern_scan_ctrl;
  localparam int PAT_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pat;
  logic [CNT_W-1:0] cfg_limit;
  logic             start, abort, x, x_valid;
  logic             z, busy, done;
  logic [CNT_W-1:0] match_cnt;
  logic [1:0]       state;

  pattern_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_limit(cfg_limit),
    .start(start), .abort(abort), .x(x), .x_valid(x_valid), .z(z),
    .match_cnt(match_cnt), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int z_seen   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers plus a queue of bits received since the last clear.
  int m_state, m_pat, m_limit, m_cnt;
  bit m_bits[$];

  typedef struct {
    int z;
    int st;
    int cnt;
  } exp_t;
  exp_t sbq[$];

  function automatic void model_reset();
    m_state = 0; m_pat = 6; m_limit = 0; m_cnt = 0;
    m_bits.delete();
  endfunction

  function automatic int model_z(input logic ab, input logic xb, input logic xv);
    int v;
    if (m_state != 1 || !xv || ab || m_bits.size() < PAT_W - 1) return 0;
    v = 0;
    for (int i = m_bits.size() - (PAT_W - 1); i < m_bits.size(); i++) v = (v << 1) | int'(m_bits[i]);
    v = (v << 1) | int'(xb);
    return (v == m_pat) ? 1 : 0;
  endfunction

  function automatic void model_step(input logic we, input int p, input int lim,
                                     input logic st, input logic ab, input logic xb, input logic xv);
    int mz = model_z(ab, xb, xv);
    int old = m_cnt;
    if (m_state == 1) begin
      if (ab) m_state = 0;
      else if (xv) begin
        m_bits.push_back(xb);
        if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
        if (mz == 1) begin
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
          if (m_limit != 0 && old + 1 == m_limit) m_state = 2;
`ifndef OVERLAP_EN
          m_bits.delete();
`endif
        end
      end
    end else if (ab) begin
      m_state = 0;
    end else begin
      if (we) begin m_pat = p; m_limit = lim; end
      if (st) begin m_state = 1; m_cnt = 0; m_bits.delete(); end
    end
  endfunction

  // One clock of stimulus: drive after the edge, record the prediction, advance the model.
  task automatic cyc(input logic we, input int p, input int lim,
                     input logic st, input logic ab, input logic xb, input logic xv);
    exp_t e;
    @(posedge clk); #1;
    cfg_we = we; cfg_pat = PAT_W'(p); cfg_limit = CNT_W'(lim);
    start = st; abort = ab; x = xb; x_valid = xv;
    e.z = model_z(ab, xb, xv); e.st = m_state; e.cnt = m_cnt;
    sbq.push_back(e);
    model_step(we, p, lim, st, ab, xb, xv);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic feed(input logic [15:0] bits_v, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(0, 0, 0, 0, 0, bits_v[i], 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (z === 1'b1) z_seen++;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("z",     32'(z),         32'(e.z));
        check("state", 32'(state),     32'(e.st));
        check("cnt",   32'(match_cnt), 32'(e.cnt));
        check("busy",  32'(busy),      32'(e.st == 1));
        check("done",  32'(done),      32'(e.st == 2));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int z0;
    logic [15:0] r;
    rst = 1'b1; cfg_we = 1'b0; cfg_pat = '0; cfg_limit = '0;
    start = 1'b1; abort = 1'b0; x = 1'b0; x_valid = 1'b1;
    model_reset();
    #12;
    check("rst_z", 32'(z), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_state", 32'(state), 0);
    check("rst_cnt", 32'(match_cnt), 0);
    start = 1'b0; x_valid = 1'b0;
    @(negedge clk); rst = 1'b0;

    // Default pattern 0110 after reset
    z0 = z_seen;
    cyc(0, 0, 0, 1, 0, 0, 0);
    feed(16'b0110, 4);
    idle();
    check("dflt_zcount", 32'(z_seen - z0), 1);
    check("dflt_state", 32'(state), 1);
    check("dflt_cnt", 32'(match_cnt), 1);

    // Overlapping pattern 1010
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 4'b1010, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    z0 = z_seen;
    feed(16'b101010, 6);
    idle();
`ifdef OVERLAP_EN
    check("ovl_zcount", 32'(z_seen - z0), 2);
    check("ovl_cnt", 32'(match_cnt), 2);
`else
    check("ovl_zcount", 32'(z_seen - z0), 1);
    check("ovl_cnt", 32'(match_cnt), 1);
`endif

    // Limit of two matches reaches DONE, extra bit ignored
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 4'b0110, 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    z0 = z_seen;
    feed(16'b0110_0110_1, 9);
    idle();
    check("lim_zcount", 32'(z_seen - z0), 2);
    check("lim_state", 32'(state), 2);
    check("lim_done", 32'(done), 1);
    check("lim_cnt", 32'(match_cnt), 2);

    // Abort together with a matching final bit
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 4'b0110, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    z0 = z_seen;
    feed(16'b0110_011, 7);
    cyc(0, 0, 0, 0, 1, 0, 1);
    idle();
    check("abort_zcount", 32'(z_seen - z0), 1);
    check("abort_state", 32'(state), 0);
    check("abort_cnt", 32'(match_cnt), 1);

    // Gaps between valid bits
    cyc(0, 0, 0, 1, 0, 0, 0);
    z0 = z_seen;
    r = 16'b0110;
    for (int i = 3; i >= 0; i--) begin
      cyc(0, 0, 0, 0, 0, r[i], 1);
      cyc(0, 0, 0, 0, 0, ~r[i], 0);
    end
    idle();
    check("gap_zcount", 32'(z_seen - z0), 1);
    check("gap_cnt", 32'(match_cnt), 1);

    // Asynchronous reset between edges with three matches counted
    feed(16'b0110_0110, 8);
    idle();
    check("pre_rst_cnt", 32'(match_cnt), 3);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("async_state", 32'(state), 0);
    check("async_cnt", 32'(match_cnt), 0);
    check("async_busy", 32'(busy), 0);
    #1;
    rst = 1'b0;
    model_reset();

    // Counter saturation at all-ones
    cyc(1, 4'b0000, 0, 1, 0, 0, 0);
    feed(16'h0000, 0);
    for (int i = 0; i < 1100; i++) cyc(0, 0, 0, 0, 0, 1'b0, 1);
    idle();
    check("sat_cnt", 32'(match_cnt), 255);
    check("sat_state", 32'(state), 1);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int rr = $urandom_range(0, 99);
      cyc(rr >= 11 && rr < 16, $urandom_range(0, 15), $urandom_range(0, 5),
          rr >= 3 && rr < 11, rr < 3, 1'($urandom), $urandom_range(0, 9) < 7);
    end
    idle();

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sbq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
